// File: rtl/axis_gpio_cmd_rx_if.sv
// ============================================================================
// Module   : axis_gpio_cmd_rx_if
// Brief    : 8-bit AXI-stream byte channel carrying ASCII command packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_gpio_cmd_rx_if;
  logic [7:0]  s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_last;
  logic [11:0] s_axis_tuser;
  logic        s_axis_ready;

  modport master (
    output s_axis_data,
    output s_axis_valid,
    output s_axis_last,
    output s_axis_tuser,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_data,
    input  s_axis_valid,
    input  s_axis_last,
    input  s_axis_tuser,
    output s_axis_ready
  );
endinterface

`default_nettype wire

// File: rtl/axis_gpio_cmd_rx.sv
// ============================================================================
// Module   : axis_gpio_cmd_rx
// Brief    : Parses "<prefix><hex digits>[CR/LF]" stream packets into a GPIO bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_gpio_cmd_rx #(
  parameter int                        PREFIX_CHARS  = 6,
  parameter logic [8*PREFIX_CHARS-1:0] PREFIX_STRING = "LED=0x",
  parameter int                        GPIO_WIDTH    = 2,
  parameter int                        MAX_DIGITS    = 2,
  parameter int                        CHECK_LENGTH  = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  axis_gpio_cmd_rx_if.slave          s_axis,
  output logic [GPIO_WIDTH-1:0]      gpio_out,
  output logic                       gpio_update,
  output logic [15:0]                pkt_count,
  output logic [15:0]                err_count
);

  localparam logic [2:0] c_ST_PREFIX  = 3'd0;
  localparam logic [2:0] c_ST_DIGITS  = 3'd1;
  localparam logic [2:0] c_ST_TAIL    = 3'd2;
  localparam logic [2:0] c_ST_DISCARD = 3'd3;
  localparam logic [2:0] c_ST_APPLY   = 3'd4;

  localparam int                 c_IDX_W    = (PREFIX_CHARS > 1) ? $clog2(PREFIX_CHARS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PREFIX_CHARS - 1);
  localparam logic [2:0]         c_MAX_DIG  = 3'(MAX_DIGITS);

  logic [2:0]         r_state;
  logic               r_ready;
  logic [c_IDX_W-1:0] r_idx;
  logic [2:0]         r_dig;
  logic [15:0]        r_acc;
  logic [11:0]        r_byte_cnt;
  logic [11:0]        r_tuser;

  logic [7:0]         w_prefix_char;
  logic               w_is_hex;
  logic               w_is_eol;
  logic [3:0]         w_nibble;
  logic [2:0]         w_state_nx;
  logic [c_IDX_W-1:0] w_idx_nx;
  logic [2:0]         w_dig_nx;
  logic [15:0]        w_acc_nx;
  logic [11:0]        w_tuser_eff;
  logic               w_len_ok;
  logic               w_pkt_ok;
  logic               w_fire;

  assign s_axis.s_axis_ready = r_ready;
  assign w_fire = s_axis.s_axis_valid && r_ready;

  // Leftmost prefix character is the most significant byte of the literal.
  always_comb begin
    w_prefix_char = 8'h00;
    for (int i = 0; i < PREFIX_CHARS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_prefix_char = PREFIX_STRING[8*(PREFIX_CHARS-1-i) +: 8];
      end
    end
  end

  always_comb begin
    w_is_hex = 1'b0;
    w_nibble = 4'h0;
    if (s_axis.s_axis_data >= 8'h30 && s_axis.s_axis_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = s_axis.s_axis_data[3:0];
    end else if ((s_axis.s_axis_data >= 8'h41 && s_axis.s_axis_data <= 8'h46) ||
                 (s_axis.s_axis_data >= 8'h61 && s_axis.s_axis_data <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nibble = s_axis.s_axis_data[3:0] + 4'd9;
    end
  end

  assign w_is_eol = (s_axis.s_axis_data == 8'h0D) || (s_axis.s_axis_data == 8'h0A);

  // Classification of the byte currently on the bus, independent of tlast.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_dig_nx   = r_dig;
    w_acc_nx   = r_acc;
    case (r_state)
      c_ST_PREFIX: begin
        if (s_axis.s_axis_data == w_prefix_char) begin
          w_idx_nx = r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            w_state_nx = c_ST_DIGITS;
          end
        end else begin
          w_state_nx = c_ST_DISCARD;
        end
      end
      c_ST_DIGITS: begin
        if (w_is_hex) begin
          if (r_dig == c_MAX_DIG) begin
            w_state_nx = c_ST_DISCARD;
          end else begin
            w_acc_nx = {r_acc[11:0], w_nibble};
            w_dig_nx = r_dig + 3'd1;
          end
        end else if (w_is_eol && (r_dig != 3'd0)) begin
          w_state_nx = c_ST_TAIL;
        end else begin
          w_state_nx = c_ST_DISCARD;
        end
      end
      c_ST_TAIL: begin
        if (!w_is_eol) begin
          w_state_nx = c_ST_DISCARD;
        end
      end
      default: ;
    endcase
  end

  // A single-byte packet has not latched tuser yet, so use the live value.
  assign w_tuser_eff = (r_byte_cnt == 12'd0) ? s_axis.s_axis_tuser : r_tuser;
  assign w_len_ok    = (CHECK_LENGTH == 0) || (w_tuser_eff == r_byte_cnt + 12'd1);
  assign w_pkt_ok    = ((w_state_nx == c_ST_DIGITS) || (w_state_nx == c_ST_TAIL)) &&
                       (w_dig_nx != 3'd0) &&
                       ((w_acc_nx >> GPIO_WIDTH) == 16'd0) &&
                       w_len_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_PREFIX;
      r_ready     <= 1'b0;
      r_idx       <= '0;
      r_dig       <= 3'd0;
      r_acc       <= 16'd0;
      r_byte_cnt  <= 12'd0;
      r_tuser     <= 12'd0;
      gpio_out    <= '0;
      gpio_update <= 1'b0;
      pkt_count   <= 16'd0;
      err_count   <= 16'd0;
    end else begin
      gpio_update <= 1'b0;
      r_ready     <= 1'b1;
      if (r_state == c_ST_APPLY) begin
        gpio_out    <= r_acc[GPIO_WIDTH-1:0];
        gpio_update <= 1'b1;
        if (pkt_count != 16'hFFFF) begin
          pkt_count <= pkt_count + 16'd1;
        end
        r_acc   <= 16'd0;
        r_state <= c_ST_PREFIX;
      end else if (w_fire) begin
        if (r_byte_cnt == 12'd0) begin
          r_tuser <= s_axis.s_axis_tuser;
        end
        if (s_axis.s_axis_last) begin
          r_idx      <= '0;
          r_dig      <= 3'd0;
          r_byte_cnt <= 12'd0;
          if (w_pkt_ok) begin
            r_acc   <= w_acc_nx;
            r_state <= c_ST_APPLY;
            r_ready <= 1'b0;
          end else begin
            r_acc   <= 16'd0;
            r_state <= c_ST_PREFIX;
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
          end
        end else begin
          r_state    <= w_state_nx;
          r_idx      <= w_idx_nx;
          r_dig      <= w_dig_nx;
          r_acc      <= w_acc_nx;
          r_byte_cnt <= r_byte_cnt + 12'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_gpio_cmd_rx.sv
// ============================================================================
// Module   : tb_axis_gpio_cmd_rx
// Brief    : Self-checking bench: packet vector table plus scoreboard of GPIO updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_gpio_cmd_rx;

  typedef struct {
    logic [95:0] txt;
    int          len;
    int          tuser;
    bit          ok;
    logic [1:0]  gpio;
  } vec_t;

  typedef struct {
    logic [1:0] gpio;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tb_data;
  logic        tb_valid;
  logic        tb_last;
  logic [11:0] tb_tuser;
  logic        sel2;
  logic        w_ready;

  logic [1:0]  gpio_out,  gpio_out2;
  logic        gpio_update, gpio_update2;
  logic [15:0] pkt_count, pkt_count2;
  logic [15:0] err_count, err_count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc;
  int mon_pkt = 0;
  int exp_err = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_gpio_cmd_rx_if bus1 ();
  axis_gpio_cmd_rx_if bus2 ();

  assign bus1.s_axis_data  = tb_data;
  assign bus1.s_axis_last  = tb_last;
  assign bus1.s_axis_tuser = tb_tuser;
  assign bus1.s_axis_valid = tb_valid & ~sel2;
  assign bus2.s_axis_data  = tb_data;
  assign bus2.s_axis_last  = tb_last;
  assign bus2.s_axis_tuser = tb_tuser;
  assign bus2.s_axis_valid = tb_valid & sel2;
  assign w_ready = sel2 ? bus2.s_axis_ready : bus1.s_axis_ready;

  axis_gpio_cmd_rx #(.CHECK_LENGTH(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis      (bus1),
    .gpio_out    (gpio_out),
    .gpio_update (gpio_update),
    .pkt_count   (pkt_count),
    .err_count   (err_count)
  );

  axis_gpio_cmd_rx #(.CHECK_LENGTH(0)) dut_nolen (
    .clk         (clk),
    .reset       (reset),
    .s_axis      (bus2),
    .gpio_out    (gpio_out2),
    .gpio_update (gpio_update2),
    .pkt_count   (pkt_count2),
    .err_count   (err_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [95:0] txt, input int len, input int tuser,
                     input bit ok, input logic [1:0] gpio);
    vec_t v;
    v.txt = txt; v.len = len; v.tuser = tuser; v.ok = ok; v.gpio = gpio;
    vecs.push_back(v);
  endtask

  // Drives one byte per handshake; returns at #1 after the final handshake edge.
  task automatic send(input logic [95:0] d, input int len, input int tuser,
                      input bit with_last, output int stall);
    int guard;
    stall = 0;
    for (int i = 0; i < len; i++) begin
      tb_data  = d[8*(len-1-i) +: 8];
      tb_last  = with_last && (i == len - 1);
      tb_tuser = 12'(tuser);
      tb_valid = 1'b1;
      guard = 0;
      while (!w_ready && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (i == 0) stall = guard;
      if (guard >= 20) begin
        total++;
        bad++;
        $display("FAIL ready_timeout actual=ready_low required=ready_high (t=%0t)", $time);
      end
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    hs_cyc   = cyc;
  endtask

  // Every gpio_update pulse must match the oldest outstanding accepted packet.
  always @(negedge clk) begin
    if (!reset && gpio_update) begin
      if (sb.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        mon_pkt++;
        chk("gpio_out", 32'(gpio_out), 32'(e.gpio));
        chk("update_latency", 32'(cyc - e.cyc), 32'd1);
        chk("pkt_count", 32'(pkt_count), 32'(mon_pkt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  st;
    bit  prev_ok;
    exp_t e;

    reset = 1'b1; tb_valid = 1'b0; tb_last = 1'b0; tb_data = 8'h00;
    tb_tuser = 12'd0; sel2 = 1'b0;

    add("LED=0x3\r\n",   9,  9, 1'b1, 2'd3);
    add("LED=0x02",      8,  8, 1'b1, 2'd2);
    add("LED=0x1\r\n",   9,  9, 1'b1, 2'd1);
    add("LEX=0x1\r\n",   9,  9, 1'b0, 2'd0);
    add("LED=0x7\r\n",   9,  9, 1'b0, 2'd0);
    add("LED=0x001",     9,  9, 1'b0, 2'd0);
    add("LED=0x1\r\n",   9,  5, 1'b0, 2'd0);
    add("LED=0x",        6,  6, 1'b0, 2'd0);
    add("L",             1,  1, 1'b0, 2'd0);
    add("LED=0x2\r\nX", 10, 10, 1'b0, 2'd0);
    add("LED=0x0\n",     8,  8, 1'b1, 2'd0);
    add("led=0x1\r\n",   9,  9, 1'b0, 2'd0);
    add("LED=0x2\r",     8,  8, 1'b1, 2'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    chk("rst_gpio_update", 32'(gpio_update), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_ready", 32'(w_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(w_ready), 32'd1);

    // Table packets are sent back-to-back.
    prev_ok = 1'b0;
    foreach (vecs[i]) begin
      send(vecs[i].txt, vecs[i].len, vecs[i].tuser, 1'b1, st);
      chk($sformatf("ready_stall_%0d", i), 32'(st), prev_ok ? 32'd1 : 32'd0);
      if (vecs[i].ok) begin
        e.gpio = vecs[i].gpio; e.cyc = hs_cyc;
        sb.push_back(e);
      end else begin
        exp_err++;
      end
      chk($sformatf("err_count_%0d", i), 32'(err_count), 32'(exp_err));
      prev_ok = vecs[i].ok;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained_table", 32'(sb.size()), 32'd0);
    chk("gpio_after_table", 32'(gpio_out), 32'd2);

    // Idle bus with tlast asserted but valid low must change nothing.
    tb_data = 8'h0A; tb_last = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tb_last = 1'b0;
    chk("idle_err_count", 32'(err_count), 32'(exp_err));
    chk("idle_pkt_count", 32'(pkt_count), 32'(mon_pkt));

    // Packet split by a valid-low gap.
    send("LED", 3, 9, 1'b0, st);
    repeat (3) @(posedge clk);
    #1;
    send("=0x1\r\n", 6, 9, 1'b1, st);
    e.gpio = 2'd1; e.cyc = hs_cyc;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    chk("split_gpio", 32'(gpio_out), 32'd1);
    chk("split_err_count", 32'(err_count), 32'(exp_err));

    // Length mismatch is accepted when length checking is disabled.
    sel2 = 1'b1;
    send("LED=0x1\r\n", 9, 5, 1'b1, st);
    @(posedge clk); #1;
    chk("nolen_gpio_update", 32'(gpio_update2), 32'd1);
    chk("nolen_gpio_out", 32'(gpio_out2), 32'd1);
    chk("nolen_pkt_count", 32'(pkt_count2), 32'd1);
    chk("nolen_err_count", 32'(err_count2), 32'd0);
    @(posedge clk); #1;
    chk("nolen_pulse_single", 32'(gpio_update2), 32'd0);
    sel2 = 1'b0;

    // Reset in the middle of a packet.
    send("LED=", 4, 9, 1'b0, st);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_gpio_out", 32'(gpio_out), 32'd0);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_ready", 32'(w_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_gpio_update", 32'(gpio_update), 32'd0);
    sb.delete();
    mon_pkt = 0;
    exp_err = 0;
    reset = 1'b0;
    send("0x2\r\n", 5, 5, 1'b1, st);
    exp_err++;
    chk("postrst_err_count", 32'(err_count), 32'(exp_err));
    chk("postrst_gpio_out", 32'(gpio_out), 32'd0);
    send("LED=0x2\r\n", 9, 9, 1'b1, st);
    e.gpio = 2'd2; e.cyc = hs_cyc;
    sb.push_back(e);
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_gpio_valid", 32'(gpio_out), 32'd2);
    chk("postrst_pkt_count", 32'(pkt_count), 32'd1);
    chk("final_err_count", 32'(err_count), 32'd1);
    chk("sb_drained_final", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
